// File: rtl/sctag_vd_byp_ctl.sv
// sctag_vd_byp_ctl: VD bypass selects, VD array write port and BIST/diag write serialisation.
// Optional saturating bypass-event counter enabled by `define SCTAG_VD_BYP_CNT_EN.
module sctag_vd_byp_ctl #(
    parameter int IDX_W = 10,
    parameter int CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rst_l,
    input  logic             vuad_acc_c1,
    input  logic [IDX_W-1:0] vuad_idx_c1,
    input  logic             vuad_wen_c3,
    input  logic             diag_wr_req,
    input  logic [IDX_W-1:0] diag_wr_idx,
    output logic             vuad_sel_rd,
    output logic             vuad_sel_c2,
    output logic             vuad_sel_c2orc3,
    output logic             vuad_sel_c4,
    output logic             vuad_sel_c2_d1,
    output logic             sel_vd_wr_data_byp,
    output logic             vd_array_wen_c4,
    output logic [IDX_W-1:0] vd_array_widx_c4,
    output logic             bistordiag_wr_vd_c4,
    output logic             diag_stall,
    output logic             diag_wr_ack,
    output logic [CNT_W-1:0] byp_cnt
);
    typedef enum logic [1:0] {IDLE, DRAIN, WRITE} state_t;
    state_t                      state_q, state_d;
    logic [5:2]                  acc_q;
    logic [5:2][IDX_W-1:0]       idx_q;
    logic [5:4]                  wen_q;
    logic                        sel_c2_d1_q, byp_q;
    logic                        m2, m3, m4, m5, diag_wr;

    // C2/C3 updates are still speculative, so any valid C2 access counts as a writer.
    assign m2 = vuad_acc_c1 & acc_q[2] & (idx_q[2] == vuad_idx_c1);
    assign m3 = vuad_acc_c1 & acc_q[3] & vuad_wen_c3 & (idx_q[3] == vuad_idx_c1);
    assign m4 = vuad_acc_c1 & wen_q[4] & (idx_q[4] == vuad_idx_c1);
    assign m5 = vuad_acc_c1 & wen_q[5] & (idx_q[5] == vuad_idx_c1);

    assign vuad_sel_c2         = m2;
    assign vuad_sel_c2orc3     = m2 | m3;
    assign vuad_sel_c4         = m4;
    assign vuad_sel_rd         = ~(m2 | m3 | m4 | m5);
    assign vuad_sel_c2_d1      = sel_c2_d1_q;
    assign sel_vd_wr_data_byp  = byp_q;

    assign diag_wr             = (state_q == WRITE);
    assign diag_stall          = (state_q == DRAIN) | diag_wr;
    assign diag_wr_ack         = diag_wr;
    assign bistordiag_wr_vd_c4 = diag_wr;
    assign vd_array_wen_c4     = wen_q[4] | diag_wr;
    assign vd_array_widx_c4    = diag_wr ? diag_wr_idx : idx_q[4];

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            wen_q       <= '0;
            sel_c2_d1_q <= 1'b0;
            byp_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= {acc_q[4:2], vuad_acc_c1};
            idx_q       <= {idx_q[4:2], vuad_idx_c1};
            wen_q       <= {wen_q[4], vuad_wen_c3 & acc_q[3]};
            sel_c2_d1_q <= m2;
            byp_q       <= m5;
        end
    end

    // The diag write waits until C1..C5 hold no access, so it never collides with a pipeline write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = diag_wr_req ? DRAIN : IDLE;
            DRAIN:   state_d = !diag_wr_req ? IDLE : (|{vuad_acc_c1, acc_q}) ? DRAIN : WRITE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SCTAG_VD_BYP_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge rclk) begin
        if (!rst_l)
            cnt_q <= '0;
        else if (!vuad_sel_rd && !(&cnt_q))
            cnt_q <= cnt_q + CNT_W'(1);
    end
    assign byp_cnt = cnt_q;
`else
    assign byp_cnt = '0;
`endif
endmodule

// File: tb/tb_sctag_vd_byp_ctl.sv
// tb_sctag_vd_byp_ctl: directed plus randomized checks of sctag_vd_byp_ctl against a history-based model.
module tb_sctag_vd_byp_ctl;
    localparam int IW = 10;
    localparam int CW = 4;
`ifdef SCTAG_VD_BYP_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          rclk = 1'b0;
    logic          rst_l, acc1, wen3, req;
    logic [IW-1:0] idx1, didx;
    logic          sel_rd, sel_c2, sel_c2orc3, sel_c4, sel_c2_d1, byp, vd_wen, bist, stall, ack;
    logic [IW-1:0] widx;
    logic [CW-1:0] cnt;
    int            errors = 0, checks = 0;

    always #5 rclk = ~rclk;

    sctag_vd_byp_ctl #(.IDX_W(IW), .CNT_W(CW)) dut (
        .rclk(rclk), .rst_l(rst_l),
        .vuad_acc_c1(acc1), .vuad_idx_c1(idx1), .vuad_wen_c3(wen3),
        .diag_wr_req(req), .diag_wr_idx(didx),
        .vuad_sel_rd(sel_rd), .vuad_sel_c2(sel_c2), .vuad_sel_c2orc3(sel_c2orc3),
        .vuad_sel_c4(sel_c4), .vuad_sel_c2_d1(sel_c2_d1), .sel_vd_wr_data_byp(byp),
        .vd_array_wen_c4(vd_wen), .vd_array_widx_c4(widx), .bistordiag_wr_vd_c4(bist),
        .diag_stall(stall), .diag_wr_ack(ack), .byp_cnt(cnt)
    );

    // h[j] holds the C1-side inputs seen j cycles ago, so stage Ck is h[k-1].
    typedef struct packed {logic acc; logic [IW-1:0] idx; logic wen3;} ent_t;
    ent_t          h [1:4];
    logic          m_drain, m_write, e_d1, e_byp, p_m2, p_m5, p_hit;
    logic [CW-1:0] e_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic a, input logic [IW-1:0] i, input logic w, input logic r,
                         input logic [IW-1:0] d, input logic rs, input bit on);
        logic m2, m3, m4, m5, w4, w5, hit;
        acc1 = a; idx1 = i; wen3 = w; req = r; didx = d; rst_l = rs;
        #2;
        w4  = h[3].acc & h[1].wen3;
        w5  = h[4].acc & h[2].wen3;
        m2  = a & h[1].acc & (h[1].idx == i);
        m3  = a & h[2].acc & w & (h[2].idx == i);
        m4  = a & w4 & (h[3].idx == i);
        m5  = a & w5 & (h[4].idx == i);
        hit = m2 | m3 | m4 | m5;
        if (on) begin
            chk("sel_rd", sel_rd, !hit);
            chk("sel_c2", sel_c2, m2);
            chk("sel_c2orc3", sel_c2orc3, m2 | m3);
            chk("sel_c4", sel_c4, m4);
            chk("sel_c2_d1", sel_c2_d1, e_d1);
            chk("wr_data_byp", byp, e_byp);
            chk("array_wen", vd_wen, w4 | m_write);
            chk("array_widx", widx, m_write ? d : h[3].idx);
            chk("bistordiag", bist, m_write);
            chk("stall", stall, m_drain | m_write);
            chk("ack", ack, m_write);
            chk("byp_cnt", cnt, e_cnt);
        end
        p_m2 = m2; p_m5 = m5; p_hit = hit;
    endtask

    task automatic tick();
        @(posedge rclk);
        if (!rst_l) begin
            for (int k = 1; k <= 4; k++) h[k] = '0;
            m_drain = 0; m_write = 0; e_d1 = 0; e_byp = 0; e_cnt = '0;
        end else begin
            e_d1 = p_m2;
            e_byp = p_m5;
            if (CNT_ON && p_hit && e_cnt != '1) e_cnt = e_cnt + 1'b1;
            if (m_write) m_write = 0;
            else if (m_drain) begin
                if (!req) m_drain = 0;
                else if (!(acc1 | h[1].acc | h[2].acc | h[3].acc | h[4].acc)) begin
                    m_drain = 0; m_write = 1;
                end
            end else if (req) m_drain = 1;
            h[4] = h[3]; h[3] = h[2]; h[2] = h[1]; h[1] = '{acc1, idx1, wen3};
        end
        @(negedge rclk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin drive(0, 0, 0, 0, 0, 1, 1); tick(); end
    endtask

    // C5 writer at idx 0x20, C4 writer at idx 0x10, then C1 probes q.
    task automatic tp3(input logic [IW-1:0] q);
        drive(1, 10'h020, 0, 0, 0, 1, 1); tick();
        drive(1, 10'h010, 0, 0, 0, 1, 1); tick();
        drive(0, 0, 1, 0, 0, 1, 1); tick();
        drive(0, 0, 1, 0, 0, 1, 1); tick();
        drive(1, q, 0, 0, 0, 1, 1);
        chk("tp3_sel_c4", sel_c4, q == 10'h010);
        chk("tp3_sel_c2orc3", sel_c2orc3, 0);
        chk("tp3_sel_rd", sel_rd, 0);
        chk("tp3_widx", widx, 10'h010);
        tick();
        drive(0, 0, 0, 0, 0, 1, 1);
        chk("tp3_wr_data_byp", byp, q == 10'h020);
        tick();
        idle(5);
    endtask

    initial begin
        int       k_ack;
        bit       acked, r_req, last_ack;
        logic     a, w, rs;
        logic [IW-1:0] i;
        for (int k = 1; k <= 4; k++) h[k] = '0;
        m_drain = 0; m_write = 0; e_d1 = 0; e_byp = 0; e_cnt = '0; p_m2 = 0; p_m5 = 0; p_hit = 0;
        @(negedge rclk);
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 10'h005, 1, 1, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 1, 1);
        chk("rst_sel_rd", sel_rd, 1);
        chk("rst_wen", vd_wen, 0);
        chk("rst_widx", widx, 0);
        chk("rst_stall", stall, 0);
        chk("rst_cnt", cnt, 0);
        tick();

        drive(1, 10'h005, 0, 0, 0, 1, 1); tick();
        drive(1, 10'h005, 0, 0, 0, 1, 1);
        chk("tp1_sel_c2", sel_c2, 1);
        chk("tp1_sel_c2orc3", sel_c2orc3, 1);
        chk("tp1_sel_rd", sel_rd, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 1);
        chk("tp1_sel_c2_d1", sel_c2_d1, 1);
        tick();
        idle(5);

        for (int pass = 0; pass < 2; pass++) begin
            drive(1, 10'h3FF, 0, 0, 0, 1, 1); tick();
            drive(1, 10'h000, 0, 0, 0, 1, 1); tick();
            drive(1, 10'h3FF, pass == 0, 0, 0, 1, 1);
            chk("tp2_sel_c2", sel_c2, 0);
            chk("tp2_sel_c2orc3", sel_c2orc3, pass == 0);
            chk("tp2_sel_rd", sel_rd, pass != 0);
            tick();
            idle(5);
        end

        tp3(10'h020);
        tp3(10'h010);

        for (int k = 0; k < 3; k++) begin drive(1, IW'($urandom), 1, 0, 0, 1, 1); tick(); end
        drive(1, IW'($urandom), 1, 1, 10'h1A2, 1, 1);
        chk("tp4_no_stall_yet", stall, 0);
        tick();
        k_ack = -1; acked = 0;
        for (int k = 0; k < 20; k++) begin
            drive(k == 1, 10'h0AA, 0, !acked, 10'h1A2, 1, 1);
            if (ack) begin
                if (!acked) k_ack = k;
                acked = 1;
                chk("tp4_wen", vd_wen, 1);
                chk("tp4_widx", widx, 10'h1A2);
                chk("tp4_bist", bist, 1);
                chk("tp4_stall", stall, 1);
            end else if (!acked) chk("tp4_drain_stall", stall, 1);
            tick();
        end
        chk("tp4_ack_cycle", k_ack, 7);

        drive(1, 10'h033, 0, 0, 0, 1, 1); tick();
        drive(0, 0, 0, 1, 10'h111, 1, 1); tick();
        drive(0, 0, 0, 1, 10'h111, 0, 1);
        chk("tp5_drain_stall", stall, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1, 1);
        chk("tp5_stall", stall, 0);
        chk("tp5_ack", ack, 0);
        chk("tp5_sel_rd", sel_rd, 1);
        tick();
        idle(3);

        for (int k = 0; k < 21; k++) begin drive(1, 10'h007, 0, 0, 0, 1, 1); tick(); end
        drive(0, 0, 0, 0, 0, 1, 1);
        chk("tp6_cnt", cnt, CNT_ON ? 4'hF : 4'h0);
        tick();

        r_req = 0; last_ack = 0;
        for (int n = 0; n < 4000; n++) begin
            a = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 3))
                0: i = '0;
                1: i = '1;
                2: i = 10'h005;
                default: i = IW'($urandom_range(0, 7));
            endcase
            w = $urandom_range(0, 1);
            rs = ($urandom_range(0, 199) != 0);
            if (last_ack) r_req = 0;
            else if (!r_req) r_req = ($urandom_range(0, 15) == 0);
            else if ($urandom_range(0, 31) == 0) r_req = 0;
            drive(a, i, w, r_req, IW'($urandom), rs, 1);
            last_ack = m_write;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
